mem_map_dma: RTL and testbench

MEM_MAP_DMA -- requirements
Module: mem_map_dma

---
 rtl/mem_map_dma.sv | 149 ++++++++++++++
 tb/tb_mem_map_dma.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_map_dma.sv
// mem_map_dma: CPU address decoder and bus mux with an SPR-RAM page DMA engine.
// Latency: zero-latency CPU passthrough when idle. A DMA stalls the CPU for
//   1 (+1 alignment cycle when enabled) + 2*DMA_LEN cycles.
// Backpressure: cpu_rdy low stalls the CPU for the whole DMA, and CPU strobes
//   are dropped while it is low.
// Ports: clk/rst_n; cpu_addr/cpu_rd/cpu_wr/cpu_wdata/cpu_rdy (CPU side);
//   mem_addr/mem_rd/mem_wr/mem_wdata/mem_rdata (unified target bus);
//   cs_rom/cs_sram/cs_ram/cs_ppu/cs_apu (chip selects);
//   rom_addr/ram_addr/ppu_reg (target-local address bits); dma_active.
// Option macro: MEM_MAP_DMA_ODD_ALIGN_EN adds an extra alignment cycle
//   (ALIGN2) when the cycle parity is odd in ALIGN.
`timescale 1ns/1ps
module mem_map_dma #(
  parameter int PRG_AW  = 15,
  parameter int RAM_AW  = 11,
  parameter int DMA_LEN = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [15:0]       cpu_addr,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [7:0]        cpu_wdata,
  input  logic [7:0]        mem_rdata,
  output logic              cpu_rdy,
  output logic [15:0]       mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [7:0]        mem_wdata,
  output logic              cs_rom,
  output logic              cs_sram,
  output logic              cs_ram,
  output logic              cs_ppu,
  output logic              cs_apu,
  output logic [PRG_AW-1:0] rom_addr,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [2:0]        ppu_reg,
  output logic              dma_active
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ALIGN,
    S_ALIGN2,
    S_READ,
    S_WRITE
  } state_t;

  localparam logic [7:0]  LAST_IDX = 8'(DMA_LEN - 1);
  localparam logic [15:0] DMA_TRIG = 16'h4014;
  localparam logic [15:0] OAM_DATA = 16'h2004;

  state_t     state;
  logic [7:0] page;
  logic [7:0] idx;
  logic [7:0] rdata_q;
  logic       parity;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      page       <= 8'h00;
      idx        <= 8'h00;
      rdata_q    <= 8'h00;
      parity     <= 1'b0;
      dma_active <= 1'b0;
    end else begin
      parity <= ~parity;
      case (state)
        S_IDLE: begin
          // The trigger write itself is also forwarded to the bus this cycle.
          if (cpu_wr && cpu_addr == DMA_TRIG) begin
            page       <= cpu_wdata;
            idx        <= 8'h00;
            state      <= S_ALIGN;
            dma_active <= 1'b1;
          end
        end
        S_ALIGN: begin
`ifdef MEM_MAP_DMA_ODD_ALIGN_EN
          if (parity) state <= S_ALIGN2;
          else        state <= S_READ;
`else
          state <= S_READ;
`endif
        end
        S_ALIGN2: state <= S_READ;
        S_READ: begin
          rdata_q <= mem_rdata;
          state   <= S_WRITE;
        end
        S_WRITE: begin
          // Hold idx on the last byte so it can never wrap inside a transfer.
          if (idx == LAST_IDX) begin
            state      <= S_IDLE;
            dma_active <= 1'b0;
          end else begin
            idx   <= idx + 8'd1;
            state <= S_READ;
          end
        end
        default: begin
          state      <= S_IDLE;
          dma_active <= 1'b0;
        end
      endcase
    end
  end

  assign cpu_rdy = ~dma_active;

  // Bus owner mux: the CPU owns the bus only in IDLE; its strobes are dropped otherwise.
  always_comb begin
    mem_addr  = cpu_addr;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_wdata = cpu_wdata;
    case (state)
      S_IDLE: begin
        mem_rd = cpu_rd;
        mem_wr = cpu_wr;
      end
      S_READ: begin
        mem_addr = {page, idx};   // no carry into page: page FFh stays in FF00h-FFFFh
        mem_rd   = 1'b1;
      end
      S_WRITE: begin
        mem_addr  = OAM_DATA;
        mem_wr    = 1'b1;
        mem_wdata = rdata_q;
      end
      default: ;
    endcase
  end

  logic bus_vld;
  assign bus_vld = mem_rd | mem_wr;

  assign cs_rom  = bus_vld &  mem_addr[15];
  assign cs_sram = bus_vld & (mem_addr[15:13] == 3'b011);
  assign cs_ram  = bus_vld & (mem_addr[15:13] == 3'b000);
  assign cs_ppu  = bus_vld & (mem_addr[15:13] == 3'b001);
  assign cs_apu  = bus_vld & (mem_addr[15:13] == 3'b010);

  assign rom_addr = mem_addr[PRG_AW-1:0];
  assign ram_addr = mem_addr[RAM_AW-1:0];
  assign ppu_reg  = mem_addr[2:0];

endmodule

// File: tb/tb_mem_map_dma.sv
`timescale 1ns/1ps
module tb_mem_map_dma;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] cpu_addr;
  logic        cpu_rd, cpu_wr;
  logic [7:0]  cpu_wdata;

  // Instance a: PRG_AW=14, full 256-byte DMA. Instance b: defaults, DMA_LEN=4.
  logic        a_rdy, a_mem_rd, a_mem_wr, a_rom, a_sram, a_ram, a_ppu, a_apu, a_act;
  logic [15:0] a_mem_addr;
  logic [7:0]  a_mem_wdata, a_rdata;
  logic [13:0] a_rom_addr;
  logic [10:0] a_ram_addr;
  logic [2:0]  a_ppu_reg;

  logic        b_rdy, b_mem_rd, b_mem_wr, b_rom, b_sram, b_ram, b_ppu, b_apu, b_act;
  logic [15:0] b_mem_addr;
  logic [7:0]  b_mem_wdata, b_rdata;
  logic [14:0] b_rom_addr;
  logic [10:0] b_ram_addr;
  logic [2:0]  b_ppu_reg;

  // Memory model: combinational read data derived from the address.
  function automatic logic [7:0] pat(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction
  assign a_rdata = a_mem_rd ? pat(a_mem_addr) : 8'h00;
  assign b_rdata = b_mem_rd ? pat(b_mem_addr) : 8'h00;

  mem_map_dma #(.PRG_AW(14), .RAM_AW(11), .DMA_LEN(256)) u_a (
    .clk(clk), .rst_n(rst_n), .cpu_addr(cpu_addr), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
    .cpu_wdata(cpu_wdata), .mem_rdata(a_rdata), .cpu_rdy(a_rdy), .mem_addr(a_mem_addr),
    .mem_rd(a_mem_rd), .mem_wr(a_mem_wr), .mem_wdata(a_mem_wdata), .cs_rom(a_rom),
    .cs_sram(a_sram), .cs_ram(a_ram), .cs_ppu(a_ppu), .cs_apu(a_apu),
    .rom_addr(a_rom_addr), .ram_addr(a_ram_addr), .ppu_reg(a_ppu_reg), .dma_active(a_act)
  );

  mem_map_dma #(.PRG_AW(15), .RAM_AW(11), .DMA_LEN(4)) u_b (
    .clk(clk), .rst_n(rst_n), .cpu_addr(cpu_addr), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
    .cpu_wdata(cpu_wdata), .mem_rdata(b_rdata), .cpu_rdy(b_rdy), .mem_addr(b_mem_addr),
    .mem_rd(b_mem_rd), .mem_wr(b_mem_wr), .mem_wdata(b_mem_wdata), .cs_rom(b_rom),
    .cs_sram(b_sram), .cs_ram(b_ram), .cs_ppu(b_ppu), .cs_apu(b_apu),
    .rom_addr(b_rom_addr), .ram_addr(b_ram_addr), .ppu_reg(b_ppu_reg), .dma_active(b_act)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0] addr;
    logic        rd;
    logic        wr;
    logic [7:0]  wdata;
    logic [4:0]  cs;    // {rom, sram, ram, ppu, apu}
    logic [1:0]  sel;   // 0 rom_addr, 1 ram_addr, 2 ppu_reg
    logic [15:0] sub;
  } vec_t;

  vec_t vt[9];

  // DMA run statistics
  int st_a, st_b, nw_a, nw_b, nr_a, nr_b, bad_a, bad_b, stray;
  logic [15:0] last_ra;

  task automatic run_dma(input logic [7:0] pg, input int abort_after);
    @(negedge clk);
    cpu_addr = 16'h4014; cpu_wr = 1'b1; cpu_rd = 1'b0; cpu_wdata = pg;
    #1;
    chk("dma_trigger_forwarded", 32'({a_mem_wr, a_mem_addr, a_mem_wdata}), 32'({1'b1, 16'h4014, pg}));
    st_a = 0; st_b = 0; nw_a = 0; nw_b = 0; nr_a = 0; nr_b = 0;
    bad_a = 0; bad_b = 0; stray = 0; last_ra = 16'h0000;
    for (int cyc = 0; cyc < 700; cyc++) begin
      @(negedge clk);
      cpu_wr = 1'b0; cpu_rd = 1'b0;
      if (cyc == 5) begin
        // Re-trigger attempt while stalled: must be neither forwarded nor latched.
        cpu_addr = 16'h4014; cpu_wr = 1'b1; cpu_wdata = 8'h77;
      end
      #1;
      if (!a_rdy) st_a++;
      if (!b_rdy) st_b++;
      if (a_mem_rd) begin
        if (a_mem_addr !== {pg, nr_a[7:0]}) bad_a++;
        last_ra = a_mem_addr;
        nr_a++;
      end
      if (a_mem_wr) begin
        if (a_mem_addr !== 16'h2004) stray++;
        else begin
          if (a_mem_wdata !== pat({pg, nw_a[7:0]})) bad_a++;
          nw_a++;
        end
      end
      if (b_mem_rd) begin
        if (b_mem_addr !== {pg, nr_b[7:0]}) bad_b++;
        nr_b++;
      end
      if (b_mem_wr) begin
        if (b_mem_addr !== 16'h2004) stray++;
        else begin
          if (b_mem_wdata !== pat({pg, nw_b[7:0]})) bad_b++;
          nw_b++;
        end
      end
      if (abort_after > 0 && nw_a == abort_after) break;
      if (a_rdy && b_rdy) break;
    end
    cpu_wr = 1'b0; cpu_rd = 1'b0;
  endtask

  initial begin
    logic [15:0] act_sub;
    int late_wr;

    cpu_addr = 16'h0000; cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_wdata = 8'h00;

    vt[0] = '{16'h0801, 1'b1, 1'b0, 8'h00, 5'b00100, 2'd1, 16'h0001};
    vt[1] = '{16'h1801, 1'b1, 1'b0, 8'h00, 5'b00100, 2'd1, 16'h0001};
    vt[2] = '{16'hC123, 1'b1, 1'b0, 8'h00, 5'b10000, 2'd0, 16'h0123};
    vt[3] = '{16'h2005, 1'b0, 1'b1, 8'h3C, 5'b00010, 2'd2, 16'h0005};
    vt[4] = '{16'h6000, 1'b0, 1'b1, 8'hA5, 5'b01000, 2'd1, 16'h0000};
    vt[5] = '{16'h4016, 1'b0, 1'b1, 8'h01, 5'b00001, 2'd1, 16'h0016};
    vt[6] = '{16'hFFFF, 1'b1, 1'b0, 8'h00, 5'b10000, 2'd0, 16'h3FFF};
    vt[7] = '{16'h07FF, 1'b0, 1'b1, 8'h99, 5'b00100, 2'd1, 16'h07FF};
    vt[8] = '{16'h2005, 1'b0, 1'b0, 8'h00, 5'b00000, 2'd2, 16'h0005};

    // Reset state
    #12;
    chk("rst_dma_active_a", 32'(a_act), 32'd0);
    chk("rst_cpu_rdy_a",    32'(a_rdy), 32'd1);
    chk("rst_dma_active_b", 32'(b_act), 32'd0);
    chk("rst_selects_idle", 32'({a_rom, a_sram, a_ram, a_ppu, a_apu}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Decode / passthrough vectors
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      cpu_addr = vt[i].addr; cpu_rd = vt[i].rd; cpu_wr = vt[i].wr; cpu_wdata = vt[i].wdata;
      #1;
      chk($sformatf("cs_vec%0d", i), 32'({a_rom, a_sram, a_ram, a_ppu, a_apu}), 32'(vt[i].cs));
      case (vt[i].sel)
        2'd0:    act_sub = 16'(a_rom_addr);
        2'd1:    act_sub = 16'(a_ram_addr);
        default: act_sub = 16'(a_ppu_reg);
      endcase
      chk($sformatf("subaddr_vec%0d", i), 32'(act_sub), 32'(vt[i].sub));
      chk($sformatf("passthru_vec%0d", i), 32'({a_mem_addr, a_mem_rd, a_mem_wr, a_mem_wdata}),
          32'({vt[i].addr, vt[i].rd, vt[i].wr, vt[i].wdata}));
    end
    @(negedge clk);
    cpu_rd = 1'b0; cpu_wr = 1'b0;

    // Full DMA from page 02h (instance b does a 4-byte DMA from the same trigger)
    run_dma(8'h02, 0);
    chk("dma02_stall_a",  32'(st_a), 32'd513);
    chk("dma02_writes_a", 32'(nw_a), 32'd256);
    chk("dma02_reads_a",  32'(nr_a), 32'd256);
    chk("dma02_data_a",   32'(bad_a), 32'd0);
    chk("dma02_stray",    32'(stray), 32'd0);
    chk("dma02_stall_b",  32'(st_b), 32'd9);
    chk("dma02_writes_b", 32'(nw_b), 32'd4);
    chk("dma02_data_b",   32'(bad_b), 32'd0);
    chk("dma02_idle_a",   32'({a_rdy, a_act}), 32'b10);

    // Page FFh: no carry past FFFFh; short DMA reads FF00h-FF03h
    run_dma(8'hFF, 0);
    chk("dmaff_stall_a",  32'(st_a), 32'd513);
    chk("dmaff_data_a",   32'(bad_a), 32'd0);
    chk("dmaff_last_rd",  32'(last_ra), 32'h0000FFFF);
    chk("dmaff_stall_b",  32'(st_b), 32'd9);
    chk("dmaff_reads_b",  32'(nr_b), 32'd4);
    chk("dmaff_writes_b", 32'(nw_b), 32'd4);
    chk("dmaff_data_b",   32'(bad_b), 32'd0);
    chk("dmaff_stray",    32'(stray), 32'd0);

    // Reset right after the 10th WRITE
    run_dma(8'h03, 10);
    chk("abort_reached_10", 32'(nw_a), 32'd10);
    chk("abort_data_a",     32'(bad_a), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("abort_dma_active", 32'(a_act), 32'd0);
    chk("abort_cpu_rdy",    32'(a_rdy), 32'd1);
    chk("abort_no_mem_wr",  32'(a_mem_wr), 32'd0);
    cpu_addr = 16'h0801; cpu_rd = 1'b1;
    #1;
    chk("abort_passthru", 32'({a_mem_addr, a_mem_rd, a_ram}), 32'({16'h0801, 1'b1, 1'b1}));
    @(negedge clk);
    cpu_rd = 1'b0;
    rst_n = 1'b1;
    late_wr = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      #1;
      if (a_mem_wr && a_mem_addr == 16'h2004) late_wr++;
      if (!a_rdy) late_wr++;
    end
    chk("abort_no_late_writes", 32'(late_wr), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
